// File: rtl/minterm_scan_ctrl_pkg.sv
// minterm_scan_ctrl_pkg: shared state encoding, counter width and table-width helper
package minterm_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/minterm_scan_ctrl_if.sv
// minterm_scan_ctrl_if: scan control, function-under-test and result signals
interface minterm_scan_ctrl_if
    import minterm_scan_ctrl_pkg::*;
#(
    parameter int N_IN = 2
);
    localparam int T = tbl_w(N_IN);

    logic            start;
    logic            abort;
    logic [T-1:0]    expected;
    logic [N_IN-1:0] dut_in;
    logic            dut_a;
    logic            dut_b;
    logic            busy;
    logic            done;
    logic            pass;
    logic [T-1:0]    table_a;
    logic [T-1:0]    table_b;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, abort, expected, dut_a, dut_b,
        input  dut_in, busy, done, pass, table_a, table_b, fail_valid, first_fail
    );

    modport slave (
        input  start, abort, expected, dut_a, dut_b,
        output dut_in, busy, done, pass, table_a, table_b, fail_valid, first_fail
    );

endinterface

// File: rtl/minterm_scan_ctrl_settle_timer.sv
// settle_timer: loadable down-counter; expire flags the last hold cycle of a minterm
module settle_timer
    import minterm_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign expire = cnt == CNT_W'(1);

endmodule

// File: rtl/minterm_scan_ctrl.sv
// minterm_scan_ctrl: walks every minterm, samples two implementations and checks them against an expected table
module minterm_scan_ctrl
    import minterm_scan_ctrl_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input logic                clk,
    input logic                rst,
    minterm_scan_ctrl_if.slave bus
);
    localparam int                T        = tbl_w(N_IN);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
    localparam state_t            FIRST    = (SETTLE == 0) ? SAMPLE : HOLD;

    state_t          state, state_nx;
    logic [T-1:0]    exp_q, ta_q, tb_q;
    logic [N_IN-1:0] idx, ff_q;
    logic            busy_q, done_q, pass_q, fv_q;
    logic            accept, stop, sample, last, mism, expire;

    assign accept = state == IDLE && bus.start && !bus.abort;
    assign stop   = state != IDLE && bus.abort;
    assign sample = state == SAMPLE && !bus.abort;
    assign last   = idx == N_IN'(T - 1);
    assign mism   = sample && (bus.dut_a != exp_q[idx] || bus.dut_b != exp_q[idx]);

    settle_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept || (sample && !last)),
        .value  (SETTLE_V),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = accept                     ? FIRST :
                   stop                       ? IDLE :
                   (state == HOLD && expire)  ? SAMPLE :
                   sample                     ? (last ? IDLE : FIRST) : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            ta_q   <= '0;
            tb_q   <= '0;
            idx    <= '0;
            ff_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                exp_q  <= bus.expected;
                ta_q   <= '0;
                tb_q   <= '0;
                idx    <= '0;
                ff_q   <= '0;
                busy_q <= 1'b1;
                pass_q <= 1'b0;
                fv_q   <= 1'b0;
            end else if (stop) begin
                idx    <= '0;
                busy_q <= 1'b0;
                pass_q <= 1'b0;
            end else if (sample) begin
                ta_q[idx] <= bus.dut_a;
                tb_q[idx] <= bus.dut_b;
                if (mism && !fv_q) begin
                    fv_q <= 1'b1;
                    ff_q <= idx;
                end
                if (last) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= !(fv_q || mism);
                end else begin
                    idx <= idx + N_IN'(1);
                end
            end
        end
    end

    assign bus.dut_in     = idx;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.table_a    = ta_q;
    assign bus.table_b    = tb_q;
    assign bus.fail_valid = fv_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// tb_minterm_scan_ctrl: directed and random scans on a 2-input/SETTLE=1 and a 3-input/SETTLE=0 controller
module tb_minterm_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] fa = '0;
    logic [7:0] fb = '0;
    logic       start_i [2];
    logic       abort_i [2];
    logic [7:0] exp_i [2];
    logic       busy_o [2], done_o [2], pass_o [2], fv_o [2];
    logic [7:0] din_o [2], ta_o [2], tb_o [2], ff_o [2];

    always #5 clk = ~clk;

    minterm_scan_ctrl_if #(.N_IN(2)) i0 ();
    minterm_scan_ctrl_if #(.N_IN(3)) i1 ();

    minterm_scan_ctrl #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(i0));
    minterm_scan_ctrl #(.N_IN(3), .SETTLE(0)) u1 (.clk(clk), .rst(rst), .bus(i1));

    // Truth-table lookups stand in for the two function implementations.
    assign i0.dut_a    = fa[i0.dut_in];
    assign i0.dut_b    = fb[i0.dut_in];
    assign i1.dut_a    = fa[i1.dut_in];
    assign i1.dut_b    = fb[i1.dut_in];
    assign i0.start    = start_i[0];
    assign i1.start    = start_i[1];
    assign i0.abort    = abort_i[0];
    assign i1.abort    = abort_i[1];
    assign i0.expected = exp_i[0][3:0];
    assign i1.expected = exp_i[1];

    assign busy_o[0] = i0.busy;
    assign busy_o[1] = i1.busy;
    assign done_o[0] = i0.done;
    assign done_o[1] = i1.done;
    assign pass_o[0] = i0.pass;
    assign pass_o[1] = i1.pass;
    assign fv_o[0]   = i0.fail_valid;
    assign fv_o[1]   = i1.fail_valid;
    assign din_o[0]  = 8'(i0.dut_in);
    assign din_o[1]  = 8'(i1.dut_in);
    assign ta_o[0]   = 8'(i0.table_a);
    assign ta_o[1]   = i1.table_a;
    assign tb_o[0]   = 8'(i0.table_b);
    assign tb_o[1]   = i1.table_b;
    assign ff_o[0]   = 8'(i0.first_fail);
    assign ff_o[1]   = 8'(i1.first_fail);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_cleared(input int inst);
        check("rst_busy", busy_o[inst], 0);
        check("rst_done", done_o[inst], 0);
        check("rst_pass", pass_o[inst], 0);
        check("rst_dut_in", din_o[inst], 0);
        check("rst_table_a", ta_o[inst], 0);
        check("rst_table_b", tb_o[inst], 0);
        check("rst_fail_valid", fv_o[inst], 0);
        check("rst_first_fail", ff_o[inst], 0);
    endtask

    // Full scan against the model: minterm m is held for SETTLE+1 cycles, done one cycle after the last sample.
    task automatic run_scan(input int inst, input logic [7:0] e, input bit already,
                            input bit chain, input logic [7:0] ne);
        int         per, t, len;
        logic [7:0] msk, ff;
        bit         fv;
        per = (inst == 0) ? 2 : 1;
        t   = (inst == 0) ? 4 : 8;
        len = t * per;
        msk = 8'((1 << t) - 1);
        if (!already) begin
            @(negedge clk);
            start_i[inst] = 1'b1;
            exp_i[inst]   = e;
        end
        @(posedge clk);
        #1 start_i[inst] = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check("dut_in", din_o[inst], 32'(c / per));
            check("busy", busy_o[inst], 1);
            check("done_early", done_o[inst], 0);
        end
        @(negedge clk);
        fv = 1'b0;
        ff = '0;
        for (int m = 0; m < t; m++)
            if (fa[m] != e[m] || fb[m] != e[m]) begin
                if (!fv) ff = 8'(m);
                fv = 1'b1;
            end
        check("done", done_o[inst], 1);
        check("busy_end", busy_o[inst], 0);
        check("table_a", ta_o[inst], fa & msk);
        check("table_b", tb_o[inst], fb & msk);
        check("pass", pass_o[inst], !fv);
        check("fail_valid", fv_o[inst], fv);
        check("first_fail", ff_o[inst], ff);
        if (chain) begin
            start_i[inst] = 1'b1;
            exp_i[inst]   = ne;
        end else begin
            @(negedge clk);
            check("done_pulse", done_o[inst], 0);
            check("pass_hold", pass_o[inst], !fv);
        end
    endtask

    initial begin
        logic [7:0] msk, e;
        int         r, t;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            abort_i[i] = 1'b0;
            exp_i[i]   = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared(0);
        check_cleared(1);
        @(posedge clk);
        #1 rst = 1'b0;

        fa = 8'h01; fb = 8'h01;
        run_scan(0, 8'h01, 0, 0, 8'h00);
        fb = 8'h00;
        run_scan(0, 8'h01, 0, 0, 8'h00);
        fa = 8'h07; fb = 8'h01;
        run_scan(0, 8'h01, 0, 0, 8'h00);

        // abort once minterm 1 has been sampled, with an ignored start earlier in the scan
        @(negedge clk);
        start_i[0] = 1'b1; exp_i[0] = 8'h01;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        @(posedge clk);
        #1 start_i[0] = 1'b1; exp_i[0] = 8'h0e;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        @(negedge clk);
        check("ignored_start_dut_in", din_o[0], 1);
        repeat (2) @(posedge clk);
        #1 abort_i[0] = 1'b1;
        @(posedge clk);
        #1 abort_i[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o[0], 0);
        check("abort_dut_in", din_o[0], 0);
        check("abort_pass", pass_o[0], 0);
        check("abort_table_a", ta_o[0], 8'h03);
        check("abort_table_b", tb_o[0], 8'h01);
        check("abort_fail_valid", fv_o[0], 1);
        check("abort_first_fail", ff_o[0], 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", done_o[0], 0);
        end
        start_i[0] = 1'b1; abort_i[0] = 1'b1;
        @(posedge clk);
        #1 start_i[0] = 1'b0; abort_i[0] = 1'b0;
        @(negedge clk);
        check("start_abort_busy", busy_o[0], 0);
        check("start_abort_table_a", ta_o[0], 8'h03);

        // reset mid-scan with start held high
        fa = 8'h01; fb = 8'h01;
        @(negedge clk);
        start_i[0] = 1'b1; exp_i[0] = 8'h01;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; start_i[0] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start_i[0] = 1'b0;
        @(negedge clk);
        check_cleared(0);
        run_scan(0, 8'h01, 0, 0, 8'h00);

        // AND3 with back-to-back start in the done cycle
        fa = 8'h80; fb = 8'h80;
        run_scan(1, 8'h80, 0, 1, 8'h80);
        run_scan(1, 8'h80, 1, 0, 8'h00);

        for (int n = 0; n < 16; n++) begin
            int inst;
            inst = n & 1;
            t    = (inst == 0) ? 4 : 8;
            msk  = 8'((1 << t) - 1);
            e    = 8'($urandom) & msk;
            r    = int'($urandom_range(0, 2));
            fa   = (r == 2) ? 8'($urandom) & msk : e;
            fb   = (r == 0) ? e : 8'($urandom) & msk;
            run_scan(inst, e, 0, 0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minterm_scan_ctrl.md
# minterm_scan_ctrl

Sequencer that exhaustively drives an N-input combinational function through every minterm, samples two candidate implementations (gate-level and expression-level) on each minterm, and assembles their truth tables. Compares both tables against an expected truth table and reports pass/fail with the first failing minterm. Sits between the lab bench and any pair of equivalent function modules, replacing hand-written stimulus sequences.

## Interface
- `N_IN`, 2, number of function inputs (1..6); table width `T = 2**N_IN`
- `SETTLE`, 1, extra hold cycles per minterm before sampling (0..15)
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  synchronous reset, active high
- `start`  in  1  begin a scan; accepted only in IDLE
- `abort`  in  1  cancel a scan in progress
- `expected`  in  T  expected table; bit m = output for minterm m; captured on accepted start
- `dut_in`  out  N_IN  drive to the function inputs; equals current minterm index, MSB = first input (`a`)
- `dut_a`  in  1  output of implementation A (gate-level)
- `dut_b`  in  1  output of implementation B (expression)
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse at scan completion
- `pass`  out  1  both tables equal `expected`; valid from `done`, held until next start
- `table_a`, `table_b`  out  T  captured truth tables
- `fail_valid`  out  1  at least one mismatch recorded
- `first_fail`  out  N_IN  lowest failing minterm index; 0 when `fail_valid`=0

## Operation
- States: IDLE, HOLD, SAMPLE (state encodings per shared header).
- IDLE: `start`=1 and `abort`=0 -> capture `expected`, clear tables, `pass`, `fail_valid`, `first_fail`; `idx`<=0, `dut_in`<=0, `busy`<=1, settle counter <= SETTLE; go HOLD (or SAMPLE directly if SETTLE=0).
- HOLD: decrement counter each cycle; at 1 -> SAMPLE.
- SAMPLE (one cycle): at its closing edge write `table_a[idx]`<=`dut_a`, `table_b[idx]`<=`dut_b`; mismatch if either differs from `expected[idx]`; on first mismatch set `fail_valid`, `first_fail`<=idx. If idx=T-1 -> IDLE, `busy`<=0, `done`<=1, `pass`<=no mismatch over the whole scan (including this minterm). Else idx+1, `dut_in`<=idx+1, reload counter, -> HOLD.
- `start` while busy: ignored. `start` and `abort` together in IDLE: abort wins, nothing captured.
- `abort` while busy: next edge -> IDLE, `busy`<=0, `done` not pulsed, `pass`<=0, `dut_in`<=0; partial tables and fail info retained.
- `start` in the cycle `done`=1 is accepted (state is already IDLE).
- X on `dut_a`/`dut_b` is not special-cased; sampled as-is.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `pass`=0, tables=0, `fail_valid`=0, `first_fail`=0, state IDLE. Reset mid-scan discards everything, overrides `start`/`abort`.
- Each minterm holds `dut_in` for exactly SETTLE+1 cycles; sampled at the last edge of that window.
- Accepted start at edge k: minterm m sampled at edge k+(m+1)(SETTLE+1); `done` high for the cycle after edge k+T(SETTLE+1).
- N_IN=2, SETTLE=1: `done` after edge k+8, `busy` high 8 cycles.
- `dut_in` changes only on edges; no combinational path from inputs to outputs.

## Structure
- Shared header `minterm_scan_defs.vh`: state localparams (IDLE=2'd0, HOLD=2'd1, SAMPLE=2'd2), width helper for `T`.
- One sub-module: `settle_timer` (loadable down-counter, width 4, `load`, `value`, `expire` output); everything else in the top.
- Target 150-250 lines RTL.

## Test plan
- NOR (`~a & ~b`) pair both correct, `expected`=4'b0001, SETTLE=1 -> `dut_in` 0,1,2,3 each 2 cycles; `table_a`=`table_b`=4'b0001, `pass`=1, `fail_valid`=0, `done` 8 cycles after start.
- B stuck-at-0, `expected`=4'b0001 -> `table_b`=4'b0000, `pass`=0, `fail_valid`=1, `first_fail`=0.
- A implements `~a | ~b` (4'b0111), `expected`=4'b0001 -> `first_fail`=1, `table_a`=4'b0111, `pass`=0.
- Abort after minterm 1 sampled -> `busy` low next edge, no `done`, `table_a`[1:0] filled, `dut_in`=0; `start` pulsed during the scan earlier had no effect.
- `rst` asserted mid-scan with `start` also high -> all outputs at reset values; new start after release gives a clean full scan.
- SETTLE=0, N_IN=3, AND3 vs `expected`=8'h80 -> one cycle per minterm, `done` 8 cycles after start, `pass`=1; back-to-back start in the `done` cycle accepted.
